// File: rtl/bus_master_if.sv
// Host-side request/response signals and peripheral strobes of the bus master.
// The shared data lines are a separate inout net on the master itself.
interface bus_master_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_DEV    = 4,
  parameter int ADDR_WIDTH = 2
);
  logic                  req;
  logic [1:0]            op;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [NUM_DEV-1:0]    cs;
  logic                  we;
  logic                  oe;
  logic                  cnt_en;

  modport master (
    input  req, op, addr, wdata,
    output rdata, busy, done, err, cs, we, oe, cnt_en
  );

  modport slave (
    output req, op, addr, wdata,
    input  rdata, busy, done, err, cs, we, oe, cnt_en
  );
endinterface

// File: rtl/bus_master.sv
// Initiator of the shared tri-state peripheral bus. Turns single-cycle host
// requests (read / write / increment) into fixed SETUP-STROBE-HOLD-FIN bus
// cycles. Every strobe, chip select and the data drive enable is a flop whose
// next value is decoded from the next state, so host inputs never reach the
// bus pins combinationally.
module bus_master #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_DEV     = 4,
  parameter int ADDR_WIDTH  = 2,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_master_if.master          bus,
  inout  wire  [DATA_WIDTH-1:0] data
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    FIN    = 3'd4
  } state_t;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam int                CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_DEV-1:0]    cs_q, cs_d;
  logic                  we_q, we_d;
  logic                  oe_q, oe_d;
  logic                  cnt_en_q, cnt_en_d;
  logic                  drv_q, drv_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  addr_bad;

  assign addr_bad = (32'(bus.addr) >= 32'(NUM_DEV));

  // Next-state sequencing, request latching and read capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          op_d    = bus.op;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          if (addr_bad || (bus.op == OP_RSV)) begin
            state_d = FIN;
            err_d   = 1'b1;
          end else if (bus.op == OP_INC) begin
            // increment pulses cnt_en for a single cycle, no wait states
            state_d = STROBE;
            cnt_d   = '0;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = CNT_LOAD;
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = (op_q == OP_INC) ? FIN : HOLD;
          if (op_q == OP_RD) begin
            rdata_d = data;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD:    state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decode the registered bus outputs from the state about to be entered.
  always_comb begin
    cs_d     = '0;
    we_d     = 1'b0;
    oe_d     = 1'b0;
    cnt_en_d = 1'b0;
    drv_d    = 1'b0;
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == FIN);
    if ((state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD)) begin
      for (int i = 0; i < NUM_DEV; i++) begin
        cs_d[i] = (addr_d == ADDR_WIDTH'(i));
      end
      drv_d = (op_d == OP_WR);
    end
    if (state_d == STROBE) begin
      oe_d     = (op_d == OP_RD);
      we_d     = (op_d == OP_WR);
      cnt_en_d = (op_d == OP_INC);
    end
  end

  // Control, strobe and read-result registers; reset aborts any cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      cs_q     <= '0;
      we_q     <= 1'b0;
      oe_q     <= 1'b0;
      cnt_en_q <= 1'b0;
      drv_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      oe_q     <= oe_d;
      cnt_en_q <= cnt_en_d;
      drv_q    <= drv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Latched request payload; only meaningful while a cycle is in flight.
  always_ff @(posedge clk) begin
    op_q    <= op_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign data       = drv_q ? wdata_q : {DATA_WIDTH{1'bz}};
  assign bus.rdata  = rdata_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.cs     = cs_q;
  assign bus.we     = we_q;
  assign bus.oe     = oe_q;
  assign bus.cnt_en = cnt_en_q;

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master: one instance with WAIT_CYCLES=1 / 4 devices
// carrying a register (dev2) and a counter (dev3), and one with WAIT_CYCLES=3 /
// 3 devices carrying a constant-read device (dev0).
module tb_bus_master;

  logic clk;
  logic reset;
  wire [7:0] data_a;
  wire [7:0] data_b;

  int total;
  int bad;

  bus_master_if #(.DATA_WIDTH(8), .NUM_DEV(4), .ADDR_WIDTH(2)) ifa ();
  bus_master_if #(.DATA_WIDTH(8), .NUM_DEV(3), .ADDR_WIDTH(2)) ifb ();

  bus_master #(.DATA_WIDTH(8), .NUM_DEV(4), .ADDR_WIDTH(2), .WAIT_CYCLES(1)) u_a (
    .clk  (clk),
    .reset(reset),
    .bus  (ifa),
    .data (data_a)
  );

  bus_master #(.DATA_WIDTH(8), .NUM_DEV(3), .ADDR_WIDTH(2), .WAIT_CYCLES(3)) u_b (
    .clk  (clk),
    .reset(reset),
    .bus  (ifb),
    .data (data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Peripheral models on bus A: dev2 register, dev3 counter.
  logic [7:0] dev2_q;
  logic [7:0] cnt3_q;
  logic       cnt3_ld;

  always_ff @(posedge clk) begin
    if (ifa.we && ifa.cs[2]) dev2_q <= data_a;
  end

  always_ff @(posedge clk) begin
    if (cnt3_ld) cnt3_q <= 8'h0F;
    else if (ifa.cnt_en && ifa.cs[3]) cnt3_q <= cnt3_q + 8'h01;
  end

  assign data_a = (ifa.oe && ifa.cs[2]) ? dev2_q :
                  (ifa.oe && ifa.cs[3]) ? cnt3_q : 8'hzz;

  // Peripheral model on bus B: dev0 returns a constant.
  assign data_b = (ifb.oe && ifb.cs[0]) ? 8'h81 : 8'hzz;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic released(input logic [7:0] v);
    return (v === 8'hzz) || (v === 8'h00);
  endfunction

  initial begin
    int seen_done;
    int d1, d2, viol, oe_cnt, done_at;
    logic b5;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    cnt3_ld = 1'b1;
    ifa.req = 1'b0; ifa.op = 2'b00; ifa.addr = '0; ifa.wdata = '0;
    ifb.req = 1'b0; ifb.op = 2'b00; ifb.addr = '0; ifb.wdata = '0;

    // reset state
    tick();
    tick();
    cnt3_ld = 1'b0;
    chk("rst_busy", ifa.busy, 1'b0);
    chk("rst_done", ifa.done, 1'b0);
    chk("rst_err", ifa.err, 1'b0);
    chk("rst_cs", ifa.cs, 4'b0000);
    chk("rst_strobes", {ifa.we, ifa.oe, ifa.cnt_en}, 3'b000);
    chk("rst_rdata", ifa.rdata, 8'h00);
    chk("rst_data_z", released(data_a), 1'b1);
    chk("rst_b_busy", ifb.busy, 1'b0);
    reset = 1'b1;
    tick();

    // reset in the middle of a write
    ifa.req = 1'b1; ifa.op = 2'b01; ifa.addr = 2'd1; ifa.wdata = 8'hA5;
    tick();
    ifa.req = 1'b0;
    chk("abort_setup_cs", ifa.cs, 4'b0010);
    chk("abort_setup_data", data_a, 8'hA5);
    tick();
    chk("abort_strobe_we", ifa.we, 1'b1);
    reset = 1'b0;
    #1;
    chk("abort_cs", ifa.cs, 4'b0000);
    chk("abort_we", ifa.we, 1'b0);
    chk("abort_data_z", released(data_a), 1'b1);
    chk("abort_busy", ifa.busy, 1'b0);
    tick();
    reset = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ifa.done) seen_done++;
    end
    chk("abort_no_done", seen_done, 0);
    chk("abort_idle", ifa.busy, 1'b0);

    // write 8'h3C to dev2 (W=1)
    ifa.req = 1'b1; ifa.op = 2'b01; ifa.addr = 2'd2; ifa.wdata = 8'h3C;
    tick();
    ifa.req = 1'b0;
    chk("wr_c1_cs", ifa.cs, 4'b0100);
    chk("wr_c1_we", ifa.we, 1'b0);
    chk("wr_c1_data", data_a, 8'h3C);
    chk("wr_c1_busy", ifa.busy, 1'b1);
    tick();
    chk("wr_c2_cs", ifa.cs, 4'b0100);
    chk("wr_c2_we_oe", {ifa.we, ifa.oe}, 2'b10);
    chk("wr_c2_data", data_a, 8'h3C);
    tick();
    chk("wr_c3_cs", ifa.cs, 4'b0100);
    chk("wr_c3_we", ifa.we, 1'b0);
    chk("wr_c3_data", data_a, 8'h3C);
    chk("wr_c3_done", ifa.done, 1'b0);
    tick();
    chk("wr_c4_done_err", {ifa.done, ifa.err}, 2'b10);
    chk("wr_c4_cs", ifa.cs, 4'b0000);
    chk("wr_c4_busy", ifa.busy, 1'b1);
    chk("wr_c4_data_z", released(data_a), 1'b1);
    chk("wr_dev2", dev2_q, 8'h3C);
    tick();
    chk("wr_c5_done", ifa.done, 1'b0);
    chk("wr_c5_busy", ifa.busy, 1'b0);

    // read dev2 back (W=1)
    ifa.req = 1'b1; ifa.op = 2'b00; ifa.addr = 2'd2;
    tick();
    ifa.req = 1'b0;
    chk("rd_c1_cs_oe", {ifa.cs, ifa.oe}, 5'b0100_0);
    tick();
    chk("rd_c2_oe", ifa.oe, 1'b1);
    chk("rd_c2_data", data_a, 8'h3C);
    tick();
    chk("rd_c3_oe", ifa.oe, 1'b0);
    chk("rd_c3_rdata", ifa.rdata, 8'h3C);
    tick();
    chk("rd_c4_done", ifa.done, 1'b1);
    chk("rd_c4_rdata", ifa.rdata, 8'h3C);
    tick();

    // increment dev3 counter from 8'h0F
    ifa.req = 1'b1; ifa.op = 2'b10; ifa.addr = 2'd3;
    tick();
    ifa.req = 1'b0;
    chk("inc_c1_strobes", {ifa.cnt_en, ifa.we, ifa.oe}, 3'b100);
    chk("inc_c1_cs", ifa.cs, 4'b1000);
    chk("inc_c1_data_z", released(data_a), 1'b1);
    tick();
    chk("inc_c2_done", ifa.done, 1'b1);
    chk("inc_c2_cnt_en", ifa.cnt_en, 1'b0);
    chk("inc_c2_cs", ifa.cs, 4'b0000);
    chk("inc_counter", cnt3_q, 8'h10);
    chk("inc_rdata_kept", ifa.rdata, 8'h3C);
    tick();

    // read the counter
    ifa.req = 1'b1; ifa.op = 2'b00; ifa.addr = 2'd3;
    tick();
    ifa.req = 1'b0;
    tick();
    tick();
    tick();
    chk("rdcnt_done", ifa.done, 1'b1);
    chk("rdcnt_rdata", ifa.rdata, 8'h10);
    tick();

    // back-to-back: req held high through two transactions
    ifa.req = 1'b1; ifa.op = 2'b01; ifa.addr = 2'd0; ifa.wdata = 8'h55;
    d1 = 0; d2 = 0; viol = 0; b5 = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (ifa.done) begin
        if (d1 == 0) d1 = c;
        else d2 = c;
      end
      if (($countones(ifa.cs) > 1) || ($countones({ifa.we, ifa.oe, ifa.cnt_en}) > 1)) viol++;
      if (c == 5) b5 = ifa.busy;
    end
    ifa.req = 1'b0;
    chk("b2b_first_done", d1, 4);
    chk("b2b_second_done", d2, 9);
    chk("b2b_gap_idle", b5, 1'b0);
    chk("b2b_exclusive", viol, 0);
    tick();
    chk("b2b_end_idle", ifa.busy, 1'b0);

    // W=3 read of dev0 on bus B
    ifb.req = 1'b1; ifb.op = 2'b00; ifb.addr = 2'd0;
    oe_cnt = 0; done_at = 0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      ifb.req = 1'b0;
      if (ifb.oe) oe_cnt++;
      if (ifb.done && (done_at == 0)) done_at = c;
    end
    chk("w3_oe_cycles", oe_cnt, 3);
    chk("w3_done_cycle", done_at, 6);
    chk("w3_rdata", ifb.rdata, 8'h81);

    // bad address on a 3-device bus
    ifb.req = 1'b1; ifb.op = 2'b00; ifb.addr = 2'd3;
    tick();
    ifb.req = 1'b0;
    chk("eaddr_done_err", {ifb.done, ifb.err}, 2'b11);
    chk("eaddr_cs", ifb.cs, 3'b000);
    chk("eaddr_busy", ifb.busy, 1'b1);
    chk("eaddr_rdata", ifb.rdata, 8'h81);
    tick();
    chk("eaddr_after", {ifb.done, ifb.err, ifb.busy}, 3'b000);

    // reserved opcode
    ifb.req = 1'b1; ifb.op = 2'b11; ifb.addr = 2'd1;
    tick();
    ifb.req = 1'b0;
    chk("eop_done_err", {ifb.done, ifb.err}, 2'b11);
    chk("eop_cs", ifb.cs, 3'b000);
    chk("eop_rdata", ifb.rdata, 8'h81);
    tick();
    chk("eop_after", {ifb.done, ifb.err, ifb.busy}, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
